// File: rtl/aclk_controller.sv
// aclk_controller: alarm clock key/button sequencing controller (Moore FSM)
// Ports:
//   clk, reset      - system clock; asynchronous active-high reset
//   one_second      - single-cycle pulse that paces the entry timeout
//   key             - 0-9 digit pressed, 4'hA-4'hF no key
//   alarm_button    - level, show alarm / commit entry to alarm register
//   time_button     - level, commit entry to current-time register
//   fast_watch_req  - level request for accelerated minutes
//   shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch - control strobes
// Build option: define ACLK_FAST_WATCH_EN to register fast_watch from fast_watch_req in SHOW_TIME.
module aclk_controller #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic       fast_watch_req,
    output logic       shift,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count,
    output logic       fast_watch
);
    localparam int W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_SEC - 1);
    typedef enum logic [2:0] {
        SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY,
        SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME
    } state_t;
    state_t state, next;
    logic [W-1:0] count;
    logic digit, timeout, counting;
    assign digit   = key <= 4'd9;
    assign timeout = one_second && count == LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= SHOW_TIME;
        else       state <= next;
    always_comb begin
        next = state;
        case (state)
            SHOW_TIME:  next = alarm_button ? SHOW_ALARM : digit ? KEY_STORED : SHOW_TIME;
            KEY_STORED: next = KEY_WAITED;
            KEY_WAITED: next = !digit ? KEY_ENTRY : timeout ? SHOW_TIME : KEY_WAITED;
            KEY_ENTRY:  next = alarm_button ? SET_ALARM_TIME : time_button ? SET_CURRENT_TIME :
                               digit ? KEY_STORED : timeout ? SHOW_TIME : KEY_ENTRY;
            SHOW_ALARM: next = alarm_button ? SHOW_ALARM : SHOW_TIME;
            default:    next = SHOW_TIME;
        endcase
    end
    // The counter only survives edges that stay inside the waiting states;
    // any exit (including a new digit to KEY_STORED) clears it.
    assign counting = (state == KEY_WAITED || state == KEY_ENTRY) &&
                      (next == KEY_WAITED || next == KEY_ENTRY);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else       count <= !counting ? '0 : (one_second && count != '1) ? count + W'(1) : count;
    assign shift         = state == KEY_STORED;
    assign show_new_time = state == KEY_STORED || state == KEY_WAITED || state == KEY_ENTRY;
    assign show_a        = state == SHOW_ALARM;
    assign load_new_a    = state == SET_ALARM_TIME;
    assign load_new_c    = state == SET_CURRENT_TIME;
    assign reset_count   = state == SET_CURRENT_TIME;
`ifdef ACLK_FAST_WATCH_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) fast_watch <= 1'b0;
        else       fast_watch <= state == SHOW_TIME ? fast_watch_req : 1'b0;
`else
    logic unused_fast_watch_req;
    assign unused_fast_watch_req = fast_watch_req;
    assign fast_watch = 1'b0;
`endif
endmodule

// File: tb/tb_aclk_controller.sv
// tb_aclk_controller: scoreboard bench for aclk_controller with per-scenario tasks
module tb_aclk_controller;
    logic clk = 1'b0, reset = 1'b1, one_second = 1'b0, alarm_button = 1'b0, time_button = 1'b0, fast_watch_req = 1'b0;
    logic [3:0] key = 4'hA;
    logic shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch;
    logic [6:0] out;
    int tests = 0, fails = 0;

    // output vector order: shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch
    localparam logic [6:0] IDLE = 7'b0000000, STORED = 7'b1100000, SNT = 7'b0100000,
                           SA = 7'b0010000, LA = 7'b0001000, LC = 7'b0000110;
`ifdef ACLK_FAST_WATCH_EN
    localparam logic [6:0] FW = 7'b0000001;
`else
    localparam logic [6:0] FW = 7'b0000000;
`endif

    typedef struct {
        logic [3:0] k;
        logic ab, tb, os, fr;
        logic [6:0] exp;
    } step_t;
    step_t stim_q[$];
    logic [6:0] exp_q[$];

    aclk_controller dut (
        .clk(clk), .reset(reset), .one_second(one_second), .key(key),
        .alarm_button(alarm_button), .time_button(time_button), .fast_watch_req(fast_watch_req),
        .shift(shift), .show_new_time(show_new_time), .show_a(show_a), .load_new_a(load_new_a),
        .load_new_c(load_new_c), .reset_count(reset_count), .fast_watch(fast_watch)
    );
    assign out = {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch};

    always #5 clk = ~clk;

    task automatic add(input logic [3:0] k, input logic ab, input logic tb, input logic os, input logic fr, input logic [6:0] exp);
        stim_q.push_back('{k: k, ab: ab, tb: tb, os: os, fr: fr, exp: exp});
    endtask

    // digit press from SHOW_TIME/KEY_ENTRY, released, settling in KEY_ENTRY
    task automatic add_digit(input logic [3:0] d);
        add(d, 0, 0, 0, 0, STORED);
        add(4'hA, 0, 0, 0, 0, SNT);
        add(4'hA, 0, 0, 0, 0, SNT);
    endtask

    task automatic add_pulses(input int n, input logic [3:0] k, input logic [6:0] exp);
        for (int i = 0; i < n; i++) begin
            add(k, 0, 0, 1, 0, exp);
            add(k, 0, 0, 0, 0, exp);
        end
    endtask

    task automatic drive(input step_t s);
        key = s.k; alarm_button = s.ab; time_button = s.tb; one_second = s.os; fast_watch_req = s.fr;
    endtask

    task automatic test_reset;
        logic [6:0] e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(IDLE);
        e = exp_q.pop_front();
        tests++;
        if (out !== e) begin fails++; $display("FAIL reset_held got=%b exp=%b", out, e); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(IDLE);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, out, e); end
        end
    endtask

    task automatic test_single_digit;
        logic [6:0] e;
        int c = 0;
        add(4'd5, 0, 0, 0, 0, STORED);
        add(4'd5, 0, 0, 0, 0, SNT);
        add(4'd5, 0, 0, 0, 0, SNT);
        add(4'hA, 0, 0, 0, 0, SNT);
        add(4'hA, 0, 0, 0, 0, SNT);
        add_pulses(9, 4'hA, SNT);
        add(4'hA, 0, 0, 1, 0, IDLE);
        add(4'hA, 0, 0, 0, 0, IDLE);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL single_digit_timeout step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
    endtask

    task automatic test_set_current_time;
        logic [6:0] e;
        int c = 0;
        add_digit(4'd1); add_digit(4'd2); add_digit(4'd3); add_digit(4'd4);
        add(4'hA, 0, 1, 0, 0, LC);
        add(4'hA, 0, 0, 0, 0, IDLE);
        add(4'hA, 0, 0, 0, 0, IDLE);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL set_current_time step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
    endtask

    task automatic test_timeout_restart;
        logic [6:0] e;
        int c = 0;
        add_digit(4'd7);
        add_pulses(9, 4'hA, SNT);
        add_digit(4'd3);
        add_pulses(9, 4'hA, SNT);
        add(4'd8, 0, 0, 1, 0, STORED);
        add(4'd8, 0, 0, 0, 0, SNT);
        add_pulses(9, 4'd8, SNT);
        add(4'd8, 0, 0, 1, 0, IDLE);
        add(4'hA, 0, 0, 0, 0, IDLE);
        add(4'hA, 0, 0, 0, 0, IDLE);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL timeout_restart step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
    endtask

    task automatic test_alarm;
        logic [6:0] e;
        int c = 0;
        add(4'd5, 1, 0, 0, 0, SA);
        for (int i = 0; i < 4; i++) add(4'hA, 1, 0, 0, 0, SA);
        add(4'hA, 0, 0, 0, 0, IDLE);
        add_digit(4'd2);
        add_pulses(9, 4'hA, SNT);
        add(4'hA, 1, 1, 1, 0, LA);
        add(4'hA, 0, 0, 0, 0, IDLE);
        add(4'hA, 0, 0, 0, 0, IDLE);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL alarm step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
    endtask

    task automatic test_reset_mid_strobe;
        logic [6:0] e;
        int c = 0;
        add_digit(4'd4);
        add(4'hA, 0, 1, 0, 0, LC);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL reset_mid_setup step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
        time_button = 1'b0;
        reset = 1'b1;
        exp_q.push_back(IDLE);
        #1;
        e = exp_q.pop_front();
        tests++;
        if (out !== e) begin fails++; $display("FAIL reset_async got=%b exp=%b", out, e); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(IDLE);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL reset_no_pending cyc=%0d got=%b exp=%b", i, out, e); end
        end
    endtask

    task automatic test_fast_watch;
        logic [6:0] e;
        int c = 0;
        add(4'hA, 0, 0, 0, 1, FW);
        add(4'hA, 0, 0, 0, 1, FW);
        add(4'd5, 0, 0, 0, 1, STORED | FW);
        add(4'hA, 0, 0, 0, 1, SNT);
        add(4'hA, 0, 0, 0, 1, SNT);
        add(4'hA, 1, 0, 0, 1, LA);
        add(4'hA, 0, 0, 0, 1, IDLE);
        add(4'hA, 0, 0, 0, 1, FW);
        add(4'hA, 0, 0, 0, 0, IDLE);
        while (stim_q.size() > 0) begin
            step_t s = stim_q.pop_front();
            drive(s);
            exp_q.push_back(s.exp);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin fails++; $display("FAIL fast_watch step=%0d got=%b exp=%b", c, out, e); end
            c++;
        end
    endtask

    initial begin
        test_reset;
        test_single_digit;
        test_set_current_time;
        test_timeout_restart;
        test_alarm;
        test_reset_mid_strobe;
        test_fast_watch;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aclk_controller.md
# aclk_controller

Key/button sequencing controller for the alarm clock. It sits between the keypad/button front end and the timekeeping datapath. It decodes key presses into shift strobes for the entry register and issues load strobes for the alarm and current-time registers. It also drives `reset_count` and `fast_watch` into the second/minute time generator, and returns to time display after an inactivity timeout counted in `one_second` pulses.

## Interface
- `TIMEOUT_SEC`, default 10: number of `one_second` pulses of inactivity in key entry before abandoning entry.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; forces SHOW_TIME and clears the timeout counter.
- `one_second` input 1: single-cycle pulse from the time generator.
- `key` input 4: 0–9 = digit pressed; 4'hA = no key; 4'hB–4'hF are treated as no key.
- `alarm_button` input 1: level, high while pressed.
- `time_button` input 1: level, high while pressed.
- `fast_watch_req` input 1: level request for accelerated minutes (used only with ACLK_FAST_WATCH_EN).
- `shift` output 1: shift current key into the entry register.
- `show_new_time` output 1: display the entry register.
- `show_a` output 1: display the alarm register.
- `load_new_a` output 1: load the entry register into the alarm register.
- `load_new_c` output 1: load the entry register into the current-time register.
- `reset_count` output 1: clear the time generator prescaler.
- `fast_watch` output 1: time generator fast mode.

## Operation
- Moore FSM. All outputs except `fast_watch` decode from the state register only. Reset state is SHOW_TIME, with every output 0 and the counter at 0.
- SHOW_TIME: all outputs 0.
  - `alarm_button` -> SHOW_ALARM.
  - Otherwise a digit key -> KEY_STORED.
  - Otherwise stay.
  - `alarm_button` has priority over a simultaneous digit.
- KEY_STORED: `shift`=1 and `show_new_time`=1 for exactly one cycle; always -> KEY_WAITED.
- KEY_WAITED: `show_new_time`=1.
  - Key released (no-key code) -> KEY_ENTRY.
  - Else timeout -> SHOW_TIME.
  - A held digit never re-shifts.
- KEY_ENTRY: `show_new_time`=1. Priority order:
  - `alarm_button` -> SET_ALARM_TIME.
  - `time_button` -> SET_CURRENT_TIME.
  - Digit -> KEY_STORED.
  - Timeout -> SHOW_TIME.
- SHOW_ALARM: `show_a`=1; `alarm_button` low -> SHOW_TIME.
- SET_ALARM_TIME: `load_new_a`=1 for one cycle; -> SHOW_TIME.
- SET_CURRENT_TIME: `load_new_c`=1 and `reset_count`=1 for the same single cycle; -> SHOW_TIME.
- Timeout counter:
  - Width is ceil(log2(TIMEOUT_SEC+1)).
  - It increments on `one_second` only in KEY_WAITED or KEY_ENTRY.
  - It clears to 0 in every other state, including on KEY_STORED entry.
  - Timeout is true when the counter equals TIMEOUT_SEC-1 and `one_second`=1. The transition happens on that edge, and the counter clears.
  - The counter saturates rather than wrapping.
- A timeout coinciding with a digit or button in KEY_ENTRY: the button or digit wins.

## Timing
- Strobe latency is one clock from the decision edge. Example: `time_button` sampled high in KEY_ENTRY at edge N gives `load_new_c`/`reset_count` high for cycle N..N+1, and SHOW_TIME from edge N+1.
- `shift` asserts in the cycle after the digit is sampled in SHOW_TIME or KEY_ENTRY.
- Each digit press produces exactly one `shift` pulse regardless of hold length.
- Reset mid-operation, including during a strobe cycle, drops all outputs to 0 immediately. No pending load completes.
- Inputs are already synchronous to `clk`; no internal synchronisers.

## Configuration
- `ACLK_FAST_WATCH_EN` defined: `fast_watch` is a register.
  - Updated each clock to `fast_watch_req` while in SHOW_TIME.
  - Forced to 0 in any other state.
  - Reset value 0.
- Not defined: `fast_watch` is constant 0 and `fast_watch_req` is ignored.

## Test plan
- Reset high, then low with `key`=4'hA and buttons low -> SHOW_TIME; all outputs 0 for 20 cycles.
- `key`=5 for 3 cycles, then 4'hA -> exactly one `shift` pulse 1 cycle after first sample; `show_new_time`=1 until exit.
- Digits 1,2,3,4 entered, then `time_button` one cycle -> `load_new_c`=1 and `reset_count`=1 for one cycle, then SHOW_TIME.
- One digit entered, then 10 `one_second` pulses with no input -> return to SHOW_TIME on the 10th pulse edge; no load strobe.
  - 9 pulses then a digit -> counter clears and no timeout.
- `alarm_button` held 5 cycles in SHOW_TIME -> `show_a`=1 for those cycles, 0 one cycle after release.
  - `alarm_button` and `time_button` together in KEY_ENTRY -> only `load_new_a` pulses.
- With `ACLK_FAST_WATCH_EN`: `fast_watch_req`=1 in SHOW_TIME -> `fast_watch`=1 next cycle, dropping to 0 one cycle after entering KEY_STORED.
  - Without the macro -> `fast_watch` stays 0.
